fpu_issue_ctrl: RTL and testbench

Pipeline-side controller that drives the FP execute unit and retires its results. It accepts one decoded FP operation at a time over a valid/ready handshake and starts the execute unit. It waits for completion, which may take one cycle or many (fdiv/fsqrt/fma), then writes the result to the FP or integer register file and accumulates fflags into the FP CSR. Its writeback port also feeds the FP forwarding path.

---
 rtl/fpu_issue_ctrl_pkg.sv | 51 +++++
 rtl/fpu_issue_ctrl_if.sv | 42 ++++
 rtl/fpu_issue_ctrl_watchdog.sv | 28 ++
 rtl/fpu_issue_ctrl.sv | 117 +++++++++++
 tb/tb_fpu_issue_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared types and defaults for the FP issue/retire controller.
// Imported by the interface, the watchdog and the controller top.
package fpu_issue_ctrl_pkg;

  localparam int unsigned FPU_MAX_LAT = 64;
  localparam int unsigned FPU_CNT_W   = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } fp_issue_state_type;

  typedef struct packed {
    logic        req_valid;
    logic        req_fwren;
    logic        req_wren;
    logic [4:0]  req_waddr;
    logic        req_fpuf;
    logic        exe_ready;
    logic [31:0] exe_result;
    logic [4:0]  exe_flags;
    logic [4:0]  csr_fflags_cur;
  } fp_issue_in_type;

  typedef struct packed {
    logic        req_ready;
    logic        exe_enable;
    logic        fwb_wren;
    logic [4:0]  fwb_waddr;
    logic [31:0] fwb_wdata;
    logic        iwb_wren;
    logic [4:0]  iwb_waddr;
    logic [31:0] iwb_wdata;
    logic        csr_fpunit;
    logic [4:0]  csr_fflags;
  } fp_issue_out_type;

  typedef struct packed {
    logic       fwren;
    logic       wren;
    logic [4:0] waddr;
    logic       fpuf;
  } fp_issue_op_type;

  // x0 is hardwired to zero, so integer writes to it are dropped.
  function automatic logic iwb_allowed(input logic wren, input logic [4:0] waddr);
    return wren & (waddr != 5'd0);
  endfunction

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// Pipeline-side bundle of the FP issue controller: request, execute unit,
// register-file writeback, FP CSR and status. master = controller side.
interface fpu_issue_ctrl_if;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic        req_fwren;
  logic        req_wren;
  logic [4:0]  req_waddr;
  logic        req_fpuf;
  logic        exe_enable;
  logic        exe_ready;
  logic [31:0] exe_result;
  logic [4:0]  exe_flags;
  logic        fwb_wren;
  logic [4:0]  fwb_waddr;
  logic [31:0] fwb_wdata;
  logic        iwb_wren;
  logic [4:0]  iwb_waddr;
  logic [31:0] iwb_wdata;
  logic [4:0]  csr_fflags_cur;
  logic        csr_fpunit;
  logic [4:0]  csr_fflags;
  logic        busy;
  logic        timeout_err;

  modport master (
    input  flush, req_valid, req_fwren, req_wren, req_waddr, req_fpuf,
           exe_ready, exe_result, exe_flags, csr_fflags_cur,
    output req_ready, exe_enable, fwb_wren, fwb_waddr, fwb_wdata,
           iwb_wren, iwb_waddr, iwb_wdata, csr_fpunit, csr_fflags,
           busy, timeout_err
  );

  modport slave (
    output flush, req_valid, req_fwren, req_wren, req_waddr, req_fpuf,
           exe_ready, exe_result, exe_flags, csr_fflags_cur,
    input  req_ready, exe_enable, fwb_wren, fwb_waddr, fwb_wdata,
           iwb_wren, iwb_waddr, iwb_wdata, csr_fpunit, csr_fflags,
           busy, timeout_err
  );
endinterface

// File: rtl/fpu_issue_ctrl_watchdog.sv
// EXEC-latency counter: counts cycles spent in EXEC and flags the last
// permitted cycle. Cleared on accept, flush and reset.
module fpu_issue_watchdog #(
  parameter int unsigned MAX_LAT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expire
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    // NOTE: clocked state uses <= so every flop samples pre-edge values.
    if (!reset)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (run && !expire)
      count <= count + CNT_W'(1);
  end

  assign expire = (count == CNT_W'(MAX_LAT - 1));

endmodule

// File: rtl/fpu_issue_ctrl.sv
// FP issue/retire controller: accepts one decoded FP op, starts the execute
// unit, waits for its result and retires it to the FP/int RF and fflags CSR.
module fpu_issue_ctrl
  import fpu_issue_ctrl_pkg::*;
#(
  parameter int unsigned MAX_LAT = FPU_MAX_LAT,
  parameter int unsigned CNT_W   = FPU_CNT_W
) (
  input logic             clock,
  input logic             reset,
  fpu_issue_ctrl_if.master bus
);

  fp_issue_in_type    d;
  fp_issue_out_type   q;
  fp_issue_state_type state, state_nxt;
  fp_issue_op_type    op;
  logic [4:0]         flags_q, waddr_q;
  logic [31:0]        wdata_q;
  logic               exe_en_q, timeout_q, timeout_nxt;
  logic               flush, accept, capture, wb_fire, expire;

  assign d = '{req_valid: bus.req_valid, req_fwren: bus.req_fwren, req_wren: bus.req_wren,
               req_waddr: bus.req_waddr, req_fpuf: bus.req_fpuf, exe_ready: bus.exe_ready,
               exe_result: bus.exe_result, exe_flags: bus.exe_flags,
               csr_fflags_cur: bus.csr_fflags_cur};
  assign flush = bus.flush;

  assign accept  = d.req_valid & q.req_ready;
  assign capture = (state == EXEC) & d.exe_ready & !flush;
  assign wb_fire = (state == WB) & !flush;

  fpu_issue_watchdog #(.MAX_LAT(MAX_LAT), .CNT_W(CNT_W)) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (accept | flush),
    .run    (state == EXEC),
    .expire (expire)
  );

  always_comb begin
    // NOTE: defaults first so no path through the block leaves a latch.
    state_nxt   = state;
    timeout_nxt = 1'b0;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (accept) state_nxt = EXEC;
        EXEC: begin
          // A result in the last permitted cycle still wins over the abort.
          if (d.exe_ready) begin
            state_nxt = WB;
          end else if (expire) begin
            state_nxt   = IDLE;
            timeout_nxt = 1'b1;
          end
        end
        WB:      state_nxt = accept ? EXEC : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      op        <= '0;
      flags_q   <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      exe_en_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      exe_en_q  <= accept;
      timeout_q <= timeout_nxt;
      if (accept)
        op <= '{fwren: d.req_fwren, wren: d.req_wren & !d.req_fwren,
                waddr: d.req_waddr, fpuf: d.req_fpuf};
      // Address/data are loaded only on retirement so they hold between ops.
      if (capture) begin
        flags_q <= d.exe_flags;
        wdata_q <= d.exe_result;
        waddr_q <= op.waddr;
      end
    end
  end

  always_comb begin
    q            = '0;
    q.req_ready  = !flush & ((state == IDLE) | (state == WB));
    q.exe_enable = exe_en_q & !flush;
    q.fwb_wren   = wb_fire & op.fwren;
    q.iwb_wren   = wb_fire & iwb_allowed(op.wren, op.waddr);
    q.csr_fpunit = wb_fire & op.fpuf;
    q.csr_fflags = (state == WB) ? (d.csr_fflags_cur | flags_q) : 5'd0;
    q.fwb_waddr  = waddr_q;
    q.iwb_waddr  = waddr_q;
    q.fwb_wdata  = wdata_q;
    q.iwb_wdata  = wdata_q;
  end

  assign bus.req_ready   = q.req_ready;
  assign bus.exe_enable  = q.exe_enable;
  assign bus.fwb_wren    = q.fwb_wren;
  assign bus.fwb_waddr   = q.fwb_waddr;
  assign bus.fwb_wdata   = q.fwb_wdata;
  assign bus.iwb_wren    = q.iwb_wren;
  assign bus.iwb_waddr   = q.iwb_waddr;
  assign bus.iwb_wdata   = q.iwb_wdata;
  assign bus.csr_fpunit  = q.csr_fpunit;
  assign bus.csr_fflags  = q.csr_fflags;
  assign bus.busy        = (state != IDLE);
  assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed self-checking bench for fpu_issue_ctrl: single/multi-cycle ops,
// x0 suppression, back-to-back issue, watchdog, flush and mid-op reset.
module tb_fpu_issue_ctrl;

  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clock = ~clock;

  fpu_issue_ctrl_if bus();

  fpu_issue_ctrl #(.MAX_LAT(64), .CNT_W(7)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic quiet();
    bus.flush = 1'b0;          bus.req_valid = 1'b0;
    bus.req_fwren = 1'b0;      bus.req_wren = 1'b0;
    bus.req_waddr = 5'd0;      bus.req_fpuf = 1'b0;
    bus.exe_ready = 1'b0;      bus.exe_result = 32'd0;
    bus.exe_flags = 5'd0;      bus.csr_fflags_cur = 5'd0;
  endtask

  // Presents an op for one cycle; returns in the exe_enable cycle.
  task automatic issue(input logic fw, input logic w, input logic [4:0] a, input logic f);
    bus.req_valid = 1'b1;
    bus.req_fwren = fw;
    bus.req_wren  = w;
    bus.req_waddr = a;
    bus.req_fpuf  = f;
    cyc();
    bus.req_valid = 1'b0;
  endtask

  // Returns a result in the current cycle; returns in the WB cycle.
  task automatic finish_op(input logic [31:0] res, input logic [4:0] fl);
    bus.exe_ready  = 1'b1;
    bus.exe_result = res;
    bus.exe_flags  = fl;
    cyc();
    bus.exe_ready = 1'b0;
  endtask

  initial begin
    quiet();
    reset = 1'b0;
    cyc();
    cyc();
    #1;
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_exe_enable", bus.exe_enable, 0);
    check("rst_fwb_wren", bus.fwb_wren, 0);
    check("rst_fwb_wdata", bus.fwb_wdata, 0);
    check("rst_iwb_wren", bus.iwb_wren, 0);
    check("rst_csr_fpunit", bus.csr_fpunit, 0);
    check("rst_timeout", bus.timeout_err, 0);
    reset = 1'b1;
    cyc();

    // Single-cycle FP op with fflags accumulation.
    bus.req_valid = 1'b1; bus.req_fwren = 1'b1; bus.req_waddr = 5'd5; bus.req_fpuf = 1'b1;
    #1 check("t1_ready_idle", bus.req_ready, 1);
    cyc();
    bus.req_valid = 1'b0;
    bus.exe_ready = 1'b1; bus.exe_result = 32'h3F80_0000; bus.exe_flags = 5'h01;
    #1;
    check("t1_exe_enable", bus.exe_enable, 1);
    check("t1_busy", bus.busy, 1);
    check("t1_ready_exec", bus.req_ready, 0);
    cyc();
    bus.exe_ready = 1'b0; bus.csr_fflags_cur = 5'h10;
    #1;
    check("t1_fwb_wren", bus.fwb_wren, 1);
    check("t1_fwb_waddr", bus.fwb_waddr, 5);
    check("t1_fwb_wdata", bus.fwb_wdata, 32'h3F80_0000);
    check("t1_csr_fpunit", bus.csr_fpunit, 1);
    check("t1_csr_fflags", bus.csr_fflags, 5'h11);
    check("t1_iwb_wren", bus.iwb_wren, 0);
    check("t1_exe_enable_wb", bus.exe_enable, 0);
    cyc();
    bus.csr_fflags_cur = 5'h00;
    #1;
    check("t1_fwb_wren_after", bus.fwb_wren, 0);
    check("t1_waddr_hold", bus.fwb_waddr, 5);
    check("t1_busy_after", bus.busy, 0);

    // Multi-cycle op: result in the 12th EXEC cycle -> 12 EXEC + 1 WB busy cycles.
    begin
      int busy_cnt = 0, wb_cnt = 0, ready_bad = 0;
      issue(1'b1, 1'b0, 5'd9, 1'b1);
      for (int i = 0; i < 20; i++) begin
        bus.exe_ready  = (i == 11);
        bus.exe_result = 32'h4049_0FDB;
        bus.exe_flags  = 5'h08;
        #1;
        busy_cnt += int'(bus.busy);
        wb_cnt   += int'(bus.fwb_wren);
        if (i <= 11 && bus.req_ready) ready_bad++;
        if (i == 12) begin
          check("t2_fwb_waddr", bus.fwb_waddr, 9);
          check("t2_fwb_wdata", bus.fwb_wdata, 32'h4049_0FDB);
          check("t2_csr_fflags", bus.csr_fflags, 5'h08);
        end
        cyc();
      end
      bus.exe_ready = 1'b0;
      check("t2_busy_cycles", busy_cnt, 13);
      check("t2_wb_count", wb_cnt, 1);
      check("t2_ready_in_exec", ready_bad, 0);
    end

    // Integer destination: x0 suppressed, x7 written, fwren wins over wren.
    issue(1'b0, 1'b1, 5'd0, 1'b1);
    finish_op(32'h1234_5678, 5'h02);
    #1;
    check("t3_x0_iwb_wren", bus.iwb_wren, 0);
    check("t3_x0_fwb_wren", bus.fwb_wren, 0);
    check("t3_x0_csr_fpunit", bus.csr_fpunit, 1);
    check("t3_x0_csr_fflags", bus.csr_fflags, 5'h02);
    cyc();
    issue(1'b0, 1'b1, 5'd7, 1'b0);
    finish_op(32'hCAFE_F00D, 5'h04);
    #1;
    check("t3_x7_iwb_wren", bus.iwb_wren, 1);
    check("t3_x7_iwb_waddr", bus.iwb_waddr, 7);
    check("t3_x7_iwb_wdata", bus.iwb_wdata, 32'hCAFE_F00D);
    check("t3_x7_csr_fpunit", bus.csr_fpunit, 0);
    cyc();
    issue(1'b1, 1'b1, 5'd3, 1'b0);
    finish_op(32'h0000_00AA, 5'h00);
    #1;
    check("t3_both_fwb_wren", bus.fwb_wren, 1);
    check("t3_both_iwb_wren", bus.iwb_wren, 0);
    cyc();

    // Back-to-back: req_valid held, exe_ready answers exe_enable in the same cycle.
    begin
      logic [7:0] acc_v = '0, en_v = '0, wb_v = '0;
      bus.req_valid = 1'b1; bus.req_fwren = 1'b1; bus.req_wren = 1'b0;
      bus.req_waddr = 5'd4; bus.req_fpuf = 1'b0;
      bus.exe_result = 32'h1111_1111; bus.exe_flags = 5'h00;
      for (int i = 0; i < 8; i++) begin
        #1;
        bus.exe_ready = bus.exe_enable;
        #1;
        acc_v[i] = bus.req_valid & bus.req_ready;
        en_v[i]  = bus.exe_enable;
        wb_v[i]  = bus.fwb_wren;
        cyc();
      end
      bus.req_valid = 1'b0;
      bus.exe_ready = 1'b0;
      #1;
      check("t4_last_wb", bus.fwb_wren, 1);
      check("t4_accept_pattern", acc_v, 8'h55);
      check("t4_enable_pattern", en_v, 8'hAA);
      check("t4_wb_pattern", wb_v, 8'h54);
      cyc();
      #1 check("t4_idle_after", bus.busy, 0);
    end

    // Watchdog: no exe_ready -> abort 64 cycles after exe_enable; late ready ignored.
    begin
      int to_cnt = 0, to_at = -1, wr_cnt = 0;
      issue(1'b1, 1'b0, 5'd6, 1'b1);
      for (int k = 0; k < 71; k++) begin
        bus.exe_ready = (k == 66);
        bus.exe_result = 32'hDEAD_BEEF;
        #1;
        if (bus.timeout_err) begin
          to_cnt++;
          to_at = k;
        end
        wr_cnt += int'(bus.fwb_wren | bus.iwb_wren | bus.csr_fpunit);
        cyc();
      end
      bus.exe_ready = 1'b0;
      check("t5_timeout_pulses", to_cnt, 1);
      check("t5_timeout_cycle", to_at, 64);
      check("t5_no_writes", wr_cnt, 0);
      #1 check("t5_idle", bus.busy, 0);
    end

    // Flush in the WB cycle kills the writeback and blocks a new request.
    issue(1'b1, 1'b0, 5'd8, 1'b1);
    finish_op(32'h5555_AAAA, 5'h01);
    bus.flush = 1'b1;
    bus.req_valid = 1'b1;
    #1;
    check("t6_wb_flush_fwb", bus.fwb_wren, 0);
    check("t6_wb_flush_csr", bus.csr_fpunit, 0);
    check("t6_wb_flush_ready", bus.req_ready, 0);
    cyc();
    bus.flush = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    check("t6_wb_flush_idle", bus.busy, 0);
    check("t6_wb_flush_no_enable", bus.exe_enable, 0);
    cyc();

    // Flush in the exe_enable cycle cancels the start; a later ready is ignored.
    issue(1'b1, 1'b0, 5'd10, 1'b1);
    bus.flush = 1'b1;
    #1 check("t6_exec_flush_enable", bus.exe_enable, 0);
    cyc();
    bus.flush = 1'b0;
    bus.exe_ready = 1'b1;
    #1 check("t6_exec_flush_idle", bus.busy, 0);
    cyc();
    bus.exe_ready = 1'b0;
    #1 check("t6_exec_flush_no_wb", bus.fwb_wren, 0);

    // Reset in the middle of EXEC.
    issue(1'b0, 1'b1, 5'd12, 1'b1);
    cyc();
    reset = 1'b0;
    cyc();
    #1;
    check("t6_rst_req_ready", bus.req_ready, 1);
    check("t6_rst_busy", bus.busy, 0);
    check("t6_rst_iwb_waddr", bus.iwb_waddr, 0);
    check("t6_rst_iwb_wdata", bus.iwb_wdata, 0);
    reset = 1'b1;
    cyc();
    issue(1'b1, 1'b0, 5'd2, 1'b0);
    finish_op(32'h0BAD_CAFE, 5'h00);
    #1;
    check("t6_post_rst_fwb_wren", bus.fwb_wren, 1);
    check("t6_post_rst_waddr", bus.fwb_waddr, 2);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
